// File: rtl/dlx_data_mem_resp.sv
// Word-addressed data memory for the DLX memory stage: completes each access WAIT_STATES+1 cycles after acceptance.
// Requests arriving while mem_busy is high are dropped; back-to-back accesses are accepted in the response cycle.
module dlx_data_mem_resp #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_data_write_in,
  input  logic              mem_data_wr_en,
  input  logic              mem_data_rd_en,
  output logic [DATA_W-1:0] mem_data_read_out,
  output logic              mem_data_valid,
  output logic              mem_err,
  output logic              mem_busy
);

  localparam int              IDX_W      = $clog2(DEPTH);
  localparam logic [32:0]     ADDR_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               wr_q;
  logic               rd_q;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept;
  logic               commit;
  logic [31:0]        c_addr;
  logic [DATA_W-1:0]  c_wdata;
  logic               c_wr;
  logic               c_rd;
  logic               c_bad_addr;
  logic               c_err;
  logic [IDX_W-1:0]   c_idx;

  assign accept = (state != S_WAIT) && (mem_data_rd_en || mem_data_wr_en);

  // With no wait states the access commits on its own acceptance edge, straight from the inputs.
  assign commit  = (WAIT_STATES == 0) ? accept : ((state == S_WAIT) && (cnt == '0));
  assign c_addr  = (WAIT_STATES == 0) ? mem_addr          : addr_q;
  assign c_wdata = (WAIT_STATES == 0) ? mem_data_write_in : wdata_q;
  assign c_wr    = (WAIT_STATES == 0) ? mem_data_wr_en    : wr_q;
  assign c_rd    = (WAIT_STATES == 0) ? mem_data_rd_en    : rd_q;

  assign c_bad_addr = (c_addr[1:0] != 2'b00) || ({1'b0, c_addr} >= ADDR_LIMIT);
  assign c_err      = c_bad_addr || (c_wr && c_rd);
  assign c_idx      = c_addr[IDX_W+1:2];

  assign mem_busy = (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      cnt               <= '0;
      addr_q            <= '0;
      wdata_q           <= '0;
      wr_q              <= 1'b0;
      rd_q              <= 1'b0;
      mem_data_read_out <= '0;
      mem_data_valid    <= 1'b0;
      mem_err           <= 1'b0;
    end else begin
      mem_data_valid <= commit;
      mem_err        <= commit && c_err;

      // A combined read+write is treated as a write, so read data is left alone.
      if (commit && c_rd && !c_wr) begin
        mem_data_read_out <= c_bad_addr ? '0 : mem[c_idx];
      end

      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_data_write_in;
            wr_q    <= mem_data_wr_en;
            rd_q    <= mem_data_rd_en;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The array is deliberately not reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_wr && !c_bad_addr) begin
      mem[c_idx] <= c_wdata;
    end
  end

endmodule

// File: tb/tb_dlx_data_mem_resp.sv
// Bench for dlx_data_mem_resp: one instance with two wait states, one with none, checked against a timing model.
module tb_dlx_data_mem_resp;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: WAIT_STATES=2, index 1: WAIT_STATES=0
  logic        rst  [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic        wr   [2];
  logic        rd   [2];
  logic [31:0] rdo  [2];
  logic        vld  [2];
  logic        err  [2];
  logic        busy [2];

  dlx_data_mem_resp #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(2), .CNT_W(4)) dut_ws2 (
    .clk(clk), .rst(rst[0]), .mem_addr(addr[0]), .mem_data_write_in(wdat[0]),
    .mem_data_wr_en(wr[0]), .mem_data_rd_en(rd[0]), .mem_data_read_out(rdo[0]),
    .mem_data_valid(vld[0]), .mem_err(err[0]), .mem_busy(busy[0])
  );

  dlx_data_mem_resp #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0), .CNT_W(4)) dut_ws0 (
    .clk(clk), .rst(rst[1]), .mem_addr(addr[1]), .mem_data_write_in(wdat[1]),
    .mem_data_wr_en(wr[1]), .mem_data_rd_en(rd[1]), .mem_data_read_out(rdo[1]),
    .mem_data_valid(vld[1]), .mem_err(err[1]), .mem_busy(busy[1])
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  function automatic int ws_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // ---------------- reference model: accept/complete by edge arithmetic ----------------
  int          edge_n = 0;
  bit          pend      [2];
  int          pend_edge [2];
  int          next_ok   [2];
  logic [31:0] p_addr    [2];
  logic [31:0] p_data    [2];
  bit          p_rd      [2];
  bit          p_wr      [2];
  logic [31:0] mmem      [2][DEPTH];
  logic [31:0] e_rdo     [2];
  bit          e_vld     [2];
  bit          e_err     [2];
  bit          e_busy    [2];

  task automatic model_step(input int i);
    int w;
    bit bad;
    int idx;
    w = ws_of(i);
    e_vld[i] = 1'b0;
    e_err[i] = 1'b0;
    if (rst[i]) begin
      pend[i]    = 1'b0;
      e_rdo[i]   = '0;
      next_ok[i] = edge_n + 1;
      e_busy[i]  = 1'b0;
    end else begin
      if ((rd[i] || wr[i]) && edge_n >= next_ok[i]) begin
        pend[i]      = 1'b1;
        pend_edge[i] = edge_n + w;
        next_ok[i]   = edge_n + w + 1;
        p_addr[i]    = addr[i];
        p_data[i]    = wdat[i];
        p_rd[i]      = rd[i];
        p_wr[i]      = wr[i];
      end
      if (pend[i] && pend_edge[i] == edge_n) begin
        bad = (p_addr[i] % 4 != 0) || (p_addr[i] >= 32'(DEPTH * 4));
        idx = bad ? 0 : int'(p_addr[i] / 4);
        e_vld[i] = 1'b1;
        e_err[i] = bad || (p_rd[i] && p_wr[i]);
        if (p_wr[i]) begin
          if (!bad) mmem[i][idx] = p_data[i];
        end else begin
          e_rdo[i] = bad ? 32'h0 : mmem[i][idx];
        end
        pend[i] = 1'b0;
      end
      e_busy[i] = pend[i] && (edge_n < pend_edge[i]);
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 2; i++) model_step(i);
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("valid", i, 32'(vld[i]), 32'(e_vld[i]));
        chk("err", i, 32'(err[i]), 32'(e_err[i]));
        chk("busy", i, 32'(busy[i]), 32'(e_busy[i]));
        chk("read_data", i, rdo[i], e_rdo[i]);
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic issue(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    rd[i] = r; wr[i] = w; addr[i] = a; wdat[i] = d;
    @(negedge clk);
    rd[i] = 1'b0; wr[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, output int lat, output int nbusy);
    lat = 1;
    nbusy = 0;
    while (!vld[i] && lat < 20) begin
      if (busy[i]) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!vld[i]) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: no valid within %0d cycles", i, lat);
    end
  endtask

  task automatic access(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit xerr, input logic [31:0] xrdo, input string nm);
    int lat, nb;
    issue(i, r, w, a, d);
    wait_done(i, lat, nb);
    chk({nm, "_latency"}, i, 32'(lat), 32'(1 + ws_of(i)));
    chk({nm, "_busy_cycles"}, i, 32'(nb), 32'(ws_of(i)));
    chk({nm, "_err"}, i, 32'(err[i]), 32'(xerr));
    chk({nm, "_data"}, i, rdo[i], xrdo);
  endtask

  task automatic count_valids(input int i, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (vld[i]) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int k;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
      next_ok[i] = 0; pend[i] = 1'b0; e_rdo[i] = '0;
      for (int j = 0; j < DEPTH; j++) mmem[i][j] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check_en = 1'b1;

    for (int i = 0; i < 2; i++) begin
      chk("reset_valid", i, 32'(vld[i]), 32'h0);
      chk("reset_err", i, 32'(err[i]), 32'h0);
      chk("reset_busy", i, 32'(busy[i]), 32'h0);
      chk("reset_data", i, rdo[i], 32'h0);
    end

    // Give words 0..63 known contents so random reads are defined.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 64; w++)
        access(i, 1'b0, 1'b1, 32'(w * 4), 32'h1000_0000 + 32'(w), 1'b0, 32'h0, "init");

    // ---- two wait states ----
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "ws2_write");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "ws2_read");

    // A write offered while busy must be dropped entirely.
    rd[0] = 1'b1; addr[0] = 32'h10;
    @(negedge clk);
    chk("wait_busy", 0, 32'(busy[0]), 32'h1);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h0; wdat[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    wr[0] = 1'b0;
    count_valids(0, 6, cnt);
    chk("wait_req_one_valid", 0, 32'(cnt), 32'h1);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1000_0000, "ignored_write");

    // Reset in the middle of a write abandons it.
    access(0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0, 32'h1000_0000, "zero_w8");
    wr[0] = 1'b1; addr[0] = 32'h8; wdat[0] = 32'h1234_5678;
    @(negedge clk);
    wr[0] = 1'b0;
    chk("pre_rst_busy", 0, 32'(busy[0]), 32'h1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("rst_valid", 0, 32'(vld[0]), 32'h0);
    chk("rst_err", 0, 32'(err[0]), 32'h0);
    chk("rst_busy", 0, 32'(busy[0]), 32'h0);
    chk("rst_data", 0, rdo[0], 32'h0);
    count_valids(0, 5, cnt);
    chk("rst_no_valid", 0, 32'(cnt), 32'h0);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, "rst_read8");

    // ---- zero wait states: back-to-back write then read ----
    wr[1] = 1'b1; addr[1] = 32'h0; wdat[1] = 32'h1111_1111;
    @(negedge clk);
    chk("b2b_valid1", 1, 32'(vld[1]), 32'h1);
    chk("b2b_busy1", 1, 32'(busy[1]), 32'h0);
    wr[1] = 1'b0; rd[1] = 1'b1; addr[1] = 32'h0;
    @(negedge clk);
    rd[1] = 1'b0;
    chk("b2b_valid2", 1, 32'(vld[1]), 32'h1);
    chk("b2b_busy2", 1, 32'(busy[1]), 32'h0);
    chk("b2b_data", 1, rdo[1], 32'h1111_1111);

    access(1, 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, "misaligned_read");
    access(1, 1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, 1'b1, 32'h0, "range_write");
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1111_1111, "word0_intact");
    access(1, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b1, 32'h1111_1111, "dual_req");
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5_A5A5, "dual_readback");

    // ---- randomized traffic, checked every cycle by the model ----
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 400; c++) begin
        k = int'($urandom_range(0, 99));
        if (k < 70)      a = 32'($urandom_range(0, 63)) << 2;
        else if (k < 85) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        else             a = 32'h400 + 32'($urandom_range(0, 65535));
        addr[i] = a;
        wdat[i] = $urandom;
        rd[i]   = ($urandom_range(0, 99) < 40);
        wr[i]   = ($urandom_range(0, 99) < 40);
        rst[i]  = ($urandom_range(0, 99) < 2);
        @(negedge clk);
      end
      rd[i] = 1'b0; wr[i] = 1'b0; rst[i] = 1'b0;
      repeat (5) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
